// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the alu32 execute stage.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_ZERO  = 4'b0000;
  localparam logic [3:0] OP_XOR   = 4'b0001;
  localparam logic [3:0] OP_NAND  = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_NOT   = 4'b0100;
  localparam logic [3:0] OP_XNOR  = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_SLT   = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_SUB   = 4'b1110;
  localparam logic [3:0] OP_ADD   = 4'b1111;

endpackage

// File: rtl/alu_addsub32.sv
// Combinational adder/subtractor shared by ADD, SUB, SLT and SLTU.
module alu_addsub32
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   wide_sum;

  // Subtraction is a + ~b + 1; cout therefore reads 1 when no borrow occurs.
  assign b_eff    = sub_i ? ~b_i : b_i;
  assign wide_sum = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

  assign sum_o      = wide_sum[WIDTH-1:0];
  assign cout_o     = wide_sum[WIDTH];
  assign overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu32.sv
// Registered 32-bit ALU: opcode mux plus result/flag registers.
// Define ALU_SHIFT_EN to build the SLL/SRL/SRA barrel shifter; otherwise those opcodes yield zero.
module alu32
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             status,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic             as_cout;
  logic             as_overflow;
  logic             sub;

  logic [WIDTH-1:0] out_d,      out_q;
  logic             cout_d,     cout_q;
  logic             overflow_d, overflow_q;

  assign sub = (opcode != OP_ADD);

  alu_addsub32 #(.WIDTH(WIDTH)) u_addsub (
    .a_i        (a),
    .b_i        (b),
    .sub_i      (sub),
    .sum_o      (sum),
    .cout_o     (as_cout),
    .overflow_o (as_overflow)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    out_d      = '0;
    cout_d     = 1'b0;
    overflow_d = 1'b0;
    unique case (opcode)
      OP_XOR:   out_d = a ^ b;
      OP_NAND:  out_d = ~(a & b);
      OP_NOR:   out_d = ~(a | b);
      OP_NOT:   out_d = ~a;
      OP_XNOR:  out_d = ~(a ^ b);
      OP_OR:    out_d = a | b;
      OP_AND:   out_d = a & b;
`ifdef ALU_SHIFT_EN
      OP_SLL:   out_d = a << b[4:0];
      OP_SRL:   out_d = a >> b[4:0];
      OP_SRA:   out_d = WIDTH'($signed(a) >>> b[4:0]);
`endif
      // Signed less-than is the sign of a-b corrected by overflow; unsigned is the borrow.
      OP_SLT:   out_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ as_overflow};
      OP_SLTU:  out_d = {{(WIDTH-1){1'b0}}, ~as_cout};
      OP_PASSB: out_d = b;
      OP_SUB, OP_ADD: begin
        out_d      = sum;
        cout_d     = as_cout;
        overflow_d = as_overflow;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (status) begin
      out_q      <= out_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vector table, hand sequences and random ops vs a reference model.
module tb_alu32;
  import alu_pkg::*;

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_cout;
    logic        exp_ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  opcode;
  logic        status;
  logic [31:0] out;
  logic        cout;
  logic        overflow;

  int total;
  int bad;

  alu32 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .status   (status),
    .out      (out),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got out=%08h cout=%0b ovf=%0b, want out=%08h cout=%0b ovf=%0b",
               name, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [33:0] dut_state();
    return {out, cout, overflow};
  endfunction

  // Reference model written from the opcode table using plain integer arithmetic.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c;
    logic        v;
    logic [32:0] w;
    int          sh;
    r  = 32'h0;
    c  = 1'b0;
    v  = 1'b0;
    sh = int'(y % 32);
    case (op)
      4'd1:  r = x ^ y;
      4'd2:  r = ~(x & y);
      4'd3:  r = ~(x | y);
      4'd4:  r = ~x;
      4'd5:  r = ~(x ^ y);
      4'd6:  r = x | y;
      4'd7:  r = x & y;
      4'd8:  r = SHIFT_ON ? x << sh : 32'h0;
      4'd9:  r = SHIFT_ON ? x >> sh : 32'h0;
      4'd10: r = SHIFT_ON ? 32'($signed(x) >>> sh) : 32'h0;
      4'd11: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd12: r = (x < y) ? 32'd1 : 32'd0;
      4'd13: r = y;
      4'd14: begin
        w = {1'b0, x} + {1'b0, ~y} + 33'd1;
        r = w[31:0];
        c = w[32];
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      4'd15: begin
        w = {1'b0, x} + {1'b0, y};
        r = w[31:0];
        c = w[32];
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      default: r = 32'h0;
    endcase
    return {r, c, v};
  endfunction

  task automatic apply(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic en);
    opcode = op;
    a      = x;
    b      = y;
    status = en;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [33:0] expd;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    status = 1'b1;
    opcode = OP_ADD;
    a      = 32'd5;
    b      = 32'd7;

    #2;
    check("reset_state", dut_state(), {32'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("reset_over_status", dut_state(), {32'h0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", dut_state(), {32'd12, 1'b0, 1'b0});

    // Asynchronous clear mid-cycle, then fresh load on first enabled edge.
    apply(OP_SUB, 32'd0, 32'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", dut_state(), {32'h0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    apply(OP_ADD, 32'd5, 32'd7, 1'b1);
    check("reload_after_reset", dut_state(), {32'd12, 1'b0, 1'b0});

    vecs.push_back('{op: OP_ADD,   a: 32'h000000FF, b: 32'h000000FF, exp_out: 32'h000001FE, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_ADD,   a: 32'hFFFFFFFF, b: 32'h00000001, exp_out: 32'h00000000, exp_cout: 1'b1, exp_ov: 1'b0});
    vecs.push_back('{op: OP_ADD,   a: 32'h7FFFFFFF, b: 32'h00000001, exp_out: 32'h80000000, exp_cout: 1'b0, exp_ov: 1'b1});
    vecs.push_back('{op: OP_ADD,   a: 32'h80000000, b: 32'h80000000, exp_out: 32'h00000000, exp_cout: 1'b1, exp_ov: 1'b1});
    vecs.push_back('{op: OP_OR,    a: 32'h000000CC, b: 32'h00000033, exp_out: 32'h000000FF, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_AND,   a: 32'h000000CC, b: 32'h00000033, exp_out: 32'h00000000, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_NOT,   a: 32'h000000AA, b: 32'h12345678, exp_out: 32'hFFFFFF55, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_XOR,   a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp_out: 32'h0FF00FF0, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_NAND,  a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp_out: 32'h0FFF0FFF, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_NOR,   a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp_out: 32'h000F000F, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_XNOR,  a: 32'hF0F0F0F0, b: 32'hFF00FF00, exp_out: 32'hF00FF00F, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_ZERO,  a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp_out: 32'h00000000, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_PASSB, a: 32'h11111111, b: 32'hDEADBEEF, exp_out: 32'hDEADBEEF, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SUB,   a: 32'h00000000, b: 32'h00000001, exp_out: 32'hFFFFFFFF, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SUB,   a: 32'h80000000, b: 32'h00000001, exp_out: 32'h7FFFFFFF, exp_cout: 1'b1, exp_ov: 1'b1});
    vecs.push_back('{op: OP_SUB,   a: 32'h00000005, b: 32'h00000005, exp_out: 32'h00000000, exp_cout: 1'b1, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLT,   a: 32'h80000000, b: 32'h00000001, exp_out: 32'h00000001, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLT,   a: 32'h7FFFFFFF, b: 32'h80000000, exp_out: 32'h00000000, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLTU,  a: 32'h80000000, b: 32'h00000001, exp_out: 32'h00000000, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLTU,  a: 32'h00000001, b: 32'hFFFFFFFF, exp_out: 32'h00000001, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SRA,   a: 32'h80000000, b: 32'h00000004, exp_out: SHIFT_ON ? 32'hF8000000 : 32'h0, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SRL,   a: 32'h80000000, b: 32'h00000004, exp_out: SHIFT_ON ? 32'h08000000 : 32'h0, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLL,   a: 32'h00001234, b: 32'hFFFFFFE0, exp_out: SHIFT_ON ? 32'h00001234 : 32'h0, exp_cout: 1'b0, exp_ov: 1'b0});
    vecs.push_back('{op: OP_SLL,   a: 32'h00000003, b: 32'h0000003F, exp_out: SHIFT_ON ? 32'h80000000 : 32'h0, exp_cout: 1'b0, exp_ov: 1'b0});

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      check($sformatf("vec%0d_op%0h", i, vecs[i].op), dut_state(),
            {vecs[i].exp_out, vecs[i].exp_cout, vecs[i].exp_ov});
    end

    // Hold: outputs frozen while status is low, whatever the inputs do.
    apply(OP_ADD, 32'd3, 32'd4, 1'b1);
    check("hold_load", dut_state(), {32'd7, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      apply(OP_AND, 32'hFFFF0000 + 32'(k), 32'h0000FFFF, 1'b0);
      check($sformatf("hold_edge%0d", k), dut_state(), {32'd7, 1'b0, 1'b0});
    end
    apply(OP_SUB, 32'h80000000, 32'h00000001, 1'b0);
    check("hold_flags_input", dut_state(), {32'd7, 1'b0, 1'b0});

    // Random ops with random enable; the model tracks the held value.
    expd = dut_state();
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        ren;
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h7FFFFFFF};
      ren = ($urandom_range(0, 3) != 0);
      if (ren) expd = model(rop, ra, rb);
      apply(rop, ra, rb, ren);
      check($sformatf("rand%0d_op%0h_en%0b", n, rop, ren), dut_state(), expd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit registered arithmetic/logic unit with 4-bit opcode select and carry/overflow flags.
- Used as the datapath execute stage. Operands and opcode are sampled on the rising clock edge when enabled. Results and flags appear one cycle later and hold until the next enabled operation.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified; the shift amount uses the low 5 bits.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- a  in  32  operand A
- b  in  32  operand B
- opcode  in  4  operation select
- status  in  1  enable: 1 = execute and update outputs, 0 = hold outputs
- out  out  32  registered result
- cout  out  1  registered carry-out
- overflow  out  1  registered signed overflow

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: out=0, cout=0, overflow=0 immediately on rst assertion, independent of clk. Reset has priority over status.
- Latency: on a rising clk edge with rst=0 and status=1, out/cout/overflow take the combinational result of the current a, b, opcode.
- Hold: with status=0, all outputs keep their values.
- No handshake and no internal state beyond the three output registers.
- Opcode map (all 32-bit; cout=0 and overflow=0 unless stated):
  - 0000 ZERO: out=0
  - 0001 XOR: a^b
  - 0010 NAND: ~(a&b)
  - 0011 NOR: ~(a|b)
  - 0100 NOT: ~a; b ignored
  - 0101 XNOR: ~(a^b)
  - 0110 OR: a|b
  - 0111 AND: a&b
  - 1000 SLL: a << b[4:0]
  - 1001 SRL: a >> b[4:0], logical
  - 1010 SRA: a >>> b[4:0], arithmetic
  - 1011 SLT: out = {31'b0, signed(a)<signed(b)}
  - 1100 SLTU: out = {31'b0, a<b unsigned}
  - 1101 PASSB: out=b
  - 1110 SUB: out = a + ~b + 1
    - cout = carry out of bit 31 (1 = no borrow)
    - overflow = (a[31]!=b[31]) && (out[31]!=a[31])
  - 1111 ADD: out = a + b
    - cout = carry out of bit 31
    - overflow = (a[31]==b[31]) && (out[31]!=a[31])
- Wrap-around: ADD/SUB results are modulo 2^32; the carry is reported only via cout.
- Shift by 0 returns a unchanged; only b[4:0] is used, b[31:5] is ignored.
- Opcode or operands changing while status=0 have no effect on the outputs.
- Reset asserted mid-operation: outputs clear immediately; the first enabled edge after deassertion loads a fresh result.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: opcodes 1000/1001/1010 perform SLL/SRL/SRA as specified.
- Not defined: those opcodes produce out=0, cout=0, overflow=0, and no barrel shifter is synthesised. All other opcodes are unchanged.

Decomposition:
- Package alu_pkg holds:
  - localparams for all 16 opcode encodings (OP_ZERO ... OP_ADD)
  - the WIDTH default
- Sub-module alu_addsub32: combinational a, b, sub → sum[31:0], cout, overflow. It is shared by ADD, SUB, SLT and SLTU.
- The top level holds the opcode mux and the output registers.

Test Plan:
- Reset: assert rst with status=1, opcode=ADD, a=5, b=7 → out=0, cout=0, overflow=0 without waiting for a clock edge. After release and one edge → out=12.
- ADD: a=0x000000FF, b=0x000000FF, status=1 → next cycle out=0x000001FE, cout=0, overflow=0. Then a=0xFFFFFFFF, b=1 → out=0, cout=1. Then a=0x7FFFFFFF, b=1 → out=0x80000000, overflow=1.
- Logic ops:
  - OR a=0xCC, b=0x33 → out=0x000000FF
  - AND a=0xCC, b=0x33 → out=0
  - NOT a=0xAA → out=0xFFFFFF55
  - all with cout=0, overflow=0
- SUB: a=0, b=1 → out=0xFFFFFFFF, cout=0, overflow=0. Then a=0x80000000, b=1 → out=0x7FFFFFFF, overflow=1, cout=1.
- Enable hold: load ADD 3+4 (out=7), then status=0 with opcode=AND and new operands for 3 edges → out stays 7.
- Shifts (ALU_SHIFT_EN defined): SRA a=0x80000000, b=4 → 0xF8000000; SRL on the same operands → 0x08000000. Without the macro, both → 0.
